// File: rtl/demux1to4_stream_if.sv
// Bundles the routed input stream and the four output channels of demux1to4_stream.
// No logic of its own. Everything is declared here and driven by the endpoints.
// master drives the input beat and the sink readies; slave is the router side.
interface demux1to4_stream_if #(
    parameter int DW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*DW-1:0] out_data;
    logic [31:0]     out_cnt;

    // Source of the input beat, and owner of the four sinks.
    modport master (
        output in_valid,
        output in_data,
        output in_sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_cnt
    );

    // The router itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_cnt
    );
endinterface

// File: rtl/demux1to4_stream.sv
// Routes one valid/ready stream to one of four output channels, each with its own register and a pop counter.
// Latency is 1 cycle from the input handshake to out_valid/out_data. All outputs come from registers.
// in_ready follows only the selected channel: it is low while that channel is full and its sink is not ready.
module demux1to4_stream #(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    demux1to4_stream_if.slave  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t       ch_state [4];
    logic [DW-1:0]   ch_dat   [4];
    logic [7:0]      ch_cnt   [4];

    logic            in_hs;
    logic [3:0]      load;
    logic [3:0]      pop;

    // The selected channel can take a beat if it is empty, or if it is being drained in this same cycle.
    always_comb begin
        bus.in_ready = rst_n & ((ch_state[bus.in_sel] == EMPTY) | bus.out_ready[bus.in_sel]);
    end

    // Per-channel load and pop strobes.
    always_comb begin
        in_hs = bus.in_valid & bus.in_ready;
        load  = '0;
        pop   = '0;
        for (int k = 0; k < 4; k++) begin
            load[k] = in_hs & (bus.in_sel == 2'(k));
            pop[k]  = (ch_state[k] == FULL) & bus.out_ready[k];
        end
    end

    // Flatten the channel registers onto the output buses.
    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        bus.out_cnt   = '0;
        for (int k = 0; k < 4; k++) begin
            bus.out_valid[k]          = (ch_state[k] == FULL);
            bus.out_data[k*DW +: DW]  = ch_dat[k];
            bus.out_cnt[k*8 +: 8]     = ch_cnt[k];
        end
    end

    // Channel state machines, data registers and delivery counters.
    // A pop in the reset cycle is dropped along with everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                ch_state[k] <= EMPTY;
                ch_dat[k]   <= '0;
                ch_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (ch_state[k])
                    EMPTY: begin
                        if (load[k]) begin
                            ch_dat[k]   <= bus.in_data;
                            ch_state[k] <= FULL;
                        end
                    end
                    FULL: begin
                        // In the full state, a load can only happen alongside a pop, so the register refills back-to-back.
                        if (load[k]) begin
                            ch_dat[k] <= bus.in_data;
                        end else if (pop[k]) begin
                            ch_state[k] <= EMPTY;
                        end
                    end
                    default: ch_state[k] <= EMPTY;
                endcase
                if (pop[k]) begin
                    ch_cnt[k] <= ch_cnt[k] + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_demux1to4_stream.sv
module tb_demux1to4_stream;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux1to4_stream_if #(.DW(8)) bus ();

    demux1to4_stream #(.DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each channel is a queue of capacity one, plus the last value loaded and a delivery count.
    logic [7:0] m_q    [4][$];
    logic [7:0] m_last [4];
    int         m_cnt  [4];

    typedef struct packed {
        logic        r;
        logic        v;
        logic [1:0]  s;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_vld;
        logic [31:0] e_dat;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] m_vld();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (m_q[k].size() != 0);
        return v;
    endfunction

    function automatic logic [31:0] m_dat();
        logic [31:0] d;
        for (int k = 0; k < 4; k++) d[k*8 +: 8] = m_last[k];
        return d;
    endfunction

    function automatic logic [31:0] m_cntv();
        logic [31:0] c;
        for (int k = 0; k < 4; k++) c[k*8 +: 8] = 8'(m_cnt[k]);
        return c;
    endfunction

    // Drive one cycle of inputs, sample in_ready before the edge, then advance the model across the edge.
    // With do_chk set, in_ready and all registered outputs are compared against the model.
    task automatic step(input logic r, input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic [3:0] ordy, input logic do_chk, output logic got_rdy);
        logic exp_rdy;
        @(negedge clk);
        rst_n         = r;
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        exp_rdy = r && ((m_q[s].size() == 0) || ordy[s]);
        got_rdy = bus.in_ready;
        if (do_chk) chk("in_ready", got_rdy, exp_rdy);
        @(posedge clk);
        if (!r) begin
            for (int k = 0; k < 4; k++) begin
                m_q[k].delete();
                m_last[k] = 8'h00;
                m_cnt[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_q[k].size() != 0 && ordy[k]) begin
                    void'(m_q[k].pop_front());
                    m_cnt[k] = (m_cnt[k] + 1) % 256;
                end
            end
            if (v && exp_rdy) begin
                m_q[s].push_back(d);
                m_last[s] = d;
            end
        end
        #1;
        if (do_chk) begin
            chk("out_valid", bus.out_valid, m_vld());
            chk("out_data",  bus.out_data,  m_dat());
            chk("out_cnt",   bus.out_cnt,   m_cntv());
        end
    endtask

    initial begin
        logic rdy;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h00;
        bus.out_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            m_last[k] = 8'h00;
            m_cnt[k]  = 0;
        end

        //           r  v  s  d      ordy     rdy vld      dat            cnt
        tbl[0]  = '{1'b0, 1'b1, 2'd0, 8'hFF, 4'b1111, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        tbl[1]  = '{1'b1, 1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000, 32'h0000_0000};
        tbl[2]  = '{1'b1, 1'b1, 2'd1, 8'h11, 4'b0000, 1'b1, 4'b0110, 32'h00A5_1100, 32'h0000_0000};
        tbl[3]  = '{1'b1, 1'b1, 2'd1, 8'h22, 4'b0000, 1'b0, 4'b0110, 32'h00A5_1100, 32'h0000_0000};
        tbl[4]  = '{1'b1, 1'b1, 2'd1, 8'h22, 4'b0000, 1'b0, 4'b0110, 32'h00A5_1100, 32'h0000_0000};
        tbl[5]  = '{1'b1, 1'b1, 2'd1, 8'h22, 4'b0000, 1'b0, 4'b0110, 32'h00A5_1100, 32'h0000_0000};
        tbl[6]  = '{1'b1, 1'b1, 2'd1, 8'h22, 4'b0010, 1'b1, 4'b0110, 32'h00A5_2200, 32'h0000_0100};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b0110, 1'b1, 4'b0000, 32'h00A5_2200, 32'h0001_0200};
        tbl[8]  = '{1'b1, 1'b1, 2'd0, 8'h77, 4'b0000, 1'b1, 4'b0001, 32'h00A5_2277, 32'h0001_0200};
        tbl[9]  = '{1'b1, 1'b1, 2'd3, 8'h3C, 4'b0000, 1'b1, 4'b1001, 32'h3CA5_2277, 32'h0001_0200};
        tbl[10] = '{1'b1, 1'b1, 2'd0, 8'h99, 4'b0000, 1'b0, 4'b1001, 32'h3CA5_2277, 32'h0001_0200};
        tbl[11] = '{1'b1, 1'b0, 2'd3, 8'h00, 4'b1001, 1'b1, 4'b0000, 32'h3CA5_2277, 32'h0101_0201};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ordy, 1'b0, rdy);
            chk($sformatf("vec%0d_in_ready", i), rdy, tbl[i].e_rdy);
            chk($sformatf("vec%0d_out_valid", i), bus.out_valid, tbl[i].e_vld);
            chk($sformatf("vec%0d_out_data", i), bus.out_data, tbl[i].e_dat);
            chk($sformatf("vec%0d_out_cnt", i), bus.out_cnt, tbl[i].e_cnt);
        end

        // Streaming: eight beats into channel 2 with all sinks ready, starting from reset.
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, rdy);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 2'd2, 8'(i), 4'b1111, 1'b0, rdy);
            chk($sformatf("stream%0d_in_ready", i), rdy, 1'b1);
            chk($sformatf("stream%0d_data", i), bus.out_data[23:16], 8'(i));
            chk($sformatf("stream%0d_valid", i), bus.out_valid, 4'b0100);
        end
        step(1'b1, 1'b0, 2'd2, 8'h00, 4'b1111, 1'b0, rdy);
        chk("stream_cnt", bus.out_cnt, 32'h0008_0000);

        // Counter wrap: 256 pops on channel 0.
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, rdy);
        for (int i = 0; i < 257; i++) begin
            step(1'b1, (i < 256), 2'd0, 8'(i), 4'b0001, 1'b1, rdy);
            if (i == 255) chk("wrap_cnt255", bus.out_cnt, 32'h0000_00FF);
            if (i == 256) chk("wrap_cnt0", bus.out_cnt, 32'h0000_0000);
        end

        // Mid-operation reset with every channel full, nonzero counters, and all sinks ready.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 2'(k), 8'(8'h50 + k), 4'b0000, 1'b1, rdy);
        step(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, rdy);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 2'(k), 8'(8'h60 + k), 4'b0000, 1'b1, rdy);
        chk("pre_reset_valid", bus.out_valid, 4'b1111);
        step(1'b0, 1'b1, 2'd1, 8'hEE, 4'b1111, 1'b0, rdy);
        chk("midrst_in_ready", rdy, 1'b0);
        chk("midrst_valid", bus.out_valid, 4'b0000);
        chk("midrst_data", bus.out_data, 32'h0000_0000);
        chk("midrst_cnt", bus.out_cnt, 32'h0000_0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst_n         = 1'b1;
            bus.in_valid  = 1'b0;
            bus.in_sel    = 2'(k);
            bus.out_ready = 4'b0000;
            #1;
            chk($sformatf("post_rst_in_ready_sel%0d", k), bus.in_ready, 1'b1);
        end

        // Random traffic against the model, with the occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 8'($urandom), 4'($urandom), 1'b1, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux1to4_stream.md
# demux1to4_stream

Registered 1-to-4 demultiplexing router: one valid/ready input stream carrying a 2-bit destination select is steered to one of four independent valid/ready output channels. Each channel owns a one-entry output register and an 8-bit delivery counter. The block is the distribution end of the 4-to-1 selection path: the 4:1 muxes merge four sources into one, and this block fans one source back out to four sinks.

## Interface
Parameters:
- DW, 8, data width of input and each output channel

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low, sampled on rising edge of clk
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept the input beat (combinational)
- in_data  input  DW  input payload
- in_sel  input  2  destination channel 0..3, qualified by in_valid
- out_valid  output  4  bit k: channel k register holds a beat
- out_ready  input  4  bit k: sink k accepts the beat this cycle
- out_data  output  4*DW  channel k payload on bits [k*DW +: DW]
- out_cnt  output  32  channel k delivered-beat count on bits [k*8 +: 8]

## Operation
- Per-channel state machine, two states:
  - EMPTY (out_valid[k]=0)
  - FULL (out_valid[k]=1)
- Handshakes:
  - Input handshake: in_valid & in_ready.
  - Output handshake k: out_valid[k] & out_ready[k].
  - load_k = input handshake & (in_sel == k).
  - pop_k = output handshake k.
- in_ready = rst_n & (~out_valid[in_sel] | out_ready[in_sel]). It depends only on the selected channel; other channels never stall the input.
- Channel k transitions:
  - EMPTY, load_k: out_data_k <= in_data, go FULL.
  - FULL, pop_k and no load_k: go EMPTY. out_data_k holds its last value.
  - FULL, pop_k and load_k: stay FULL, out_data_k <= in_data. This gives back-to-back throughput of one beat per cycle per channel.
  - FULL, no pop_k: hold state and data. Input to channel k is stalled (in_ready=0 when in_sel==k).
- Counters:
  - out_cnt byte k increments by 1 on every pop_k.
  - 8-bit unsigned, wraps 255 -> 0 with no flag.
- Channels are fully independent:
  - Pops on any subset of channels may occur in the same cycle as a load to any channel.
  - Each pop is counted.
- in_data and in_sel are don't-care when in_valid=0. No state changes without a handshake.

## Timing
- Reset (rst_n=0 at a rising edge), all channels regardless of state:
  - out_valid = 4'b0000, out_data = 0, out_cnt = 0.
  - in_ready = 0 while rst_n=0.
  - A beat in flight is discarded, and a pop occurring in the reset cycle is not counted.
- First cycle after reset release: in_ready=1 for every in_sel.
- Latency:
  - Input handshake at edge N -> out_valid[k]=1 and out_data_k valid after edge N (visible in cycle N+1).
  - Minimum latency is 1 cycle. There is no combinational path from in_data to out_data.
- out_cnt updates on the same edge that completes the pop.
- Combinational paths: in_valid/in_sel/out_ready -> in_ready only. out_valid, out_data and out_cnt are registered.
- Sink rule: out_valid[k] never deasserts and out_data_k never changes while out_valid[k]=1 and out_ready[k]=0.

## Test plan
- Reset-then-route: release rst_n; send in_sel=2, in_data=8'hA5 with out_ready=4'b0000. Required: in_ready=1 in the send cycle; next cycle out_valid=4'b0100 and out_data[23:16]=8'hA5; other channels stay 0.
- Backpressure: channel 1 FULL with 8'h11 and out_ready[1]=0; present in_sel=1, in_data=8'h22 for 3 cycles. Required: in_ready=0 throughout and out_data[15:8] stays 8'h11. Then raise out_ready[1]: 8'h22 is accepted that cycle (in_ready=1), appears the next cycle, and out_cnt[15:8]=1.
- Non-blocking: channel 0 FULL and stalled; send in_sel=3, in_data=8'h3C. Required: accepted immediately, out_valid=4'b1001 next cycle, and channel 0 is unchanged.
- Streaming: out_ready=4'b1111; send 8 beats to channel 2, one per cycle, with data 0..7. Required: in_ready stays 1, out_data[23:16] shows 0..7 on consecutive cycles, and out_cnt[23:16]=8.
- Counter wrap: 256 pops on channel 0. Required: out_cnt[7:0] reads 255 after 255 pops and 0 after 256; other bytes stay 0.
- Mid-operation reset: all channels FULL and counters nonzero; assert rst_n=0 for one edge while out_ready=4'b1111. Required: next cycle out_valid=0, out_data=0, out_cnt=0, and no pop is counted.
